present_sbox_layer: RTL and testbench

- Parametrised PRESENT substitution layer for the encrypt and decrypt datapaths of the PRESENT core.
- Applies the 4-bit forward or inverse S-box to every nibble of an NLANES-nibble state.
- Processes SPC nibbles per clock, trading area against latency.
- Valid/ready handshakes on input and output, so it can be shared by round logic or driven by a bus wrapper.

---
 rtl/present_sbox_layer_if.sv | 24 ++
 rtl/present_sbox_layer.sv | 126 ++++++++++++
 tb/tb_present_sbox_layer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/present_sbox_layer_if.sv
// Valid/ready handshake bundle for the PRESENT substitution layer.
// The producer/consumer side uses master; the layer itself uses slave.
interface present_sbox_layer_if #(
    parameter int unsigned NLANES = 16
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_mode;
    logic [4*NLANES-1:0]   in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_mode;
    logic [4*NLANES-1:0]   out_data;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_mode, out_data
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_mode, out_data
    );
endinterface

// File: rtl/present_sbox_layer.sv
// PRESENT forward/inverse S-box layer over NLANES nibbles, SPC nibbles per cycle.
// A word is substituted in place over BEATS cycles, then held until the consumer takes it.
module present_sbox_layer #(
    parameter int unsigned NLANES = 16,
    parameter int unsigned SPC    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    output logic                 busy,
    present_sbox_layer_if.slave  bus
);
    localparam int unsigned W     = 4 * NLANES;
    localparam int unsigned BEATS = (SPC == 0) ? 1 : NLANES / SPC;
    localparam int unsigned KW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if ((SPC == 0) || ((NLANES % SPC) != 0)) begin : g_bad_spc
        $error("present_sbox_layer: SPC must divide NLANES");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [W-1:0]    work_q, work_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic            mode_q, mode_d;
    logic            out_mode_q, out_mode_d;
    int unsigned     base;

    function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
        unique case (x)
            4'h0: sbox_fwd = 4'hC;  4'h1: sbox_fwd = 4'h5;
            4'h2: sbox_fwd = 4'h6;  4'h3: sbox_fwd = 4'hB;
            4'h4: sbox_fwd = 4'h9;  4'h5: sbox_fwd = 4'h0;
            4'h6: sbox_fwd = 4'hA;  4'h7: sbox_fwd = 4'hD;
            4'h8: sbox_fwd = 4'h3;  4'h9: sbox_fwd = 4'hE;
            4'hA: sbox_fwd = 4'hF;  4'hB: sbox_fwd = 4'h8;
            4'hC: sbox_fwd = 4'h4;  4'hD: sbox_fwd = 4'h7;
            4'hE: sbox_fwd = 4'h1;  4'hF: sbox_fwd = 4'h2;
        endcase
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        unique case (x)
            4'h0: sbox_inv = 4'h5;  4'h1: sbox_inv = 4'hE;
            4'h2: sbox_inv = 4'hF;  4'h3: sbox_inv = 4'h8;
            4'h4: sbox_inv = 4'hC;  4'h5: sbox_inv = 4'h1;
            4'h6: sbox_inv = 4'h2;  4'h7: sbox_inv = 4'hD;
            4'h8: sbox_inv = 4'hB;  4'h9: sbox_inv = 4'h4;
            4'hA: sbox_inv = 4'h6;  4'hB: sbox_inv = 4'h3;
            4'hC: sbox_inv = 4'h0;  4'hD: sbox_inv = 4'h7;
            4'hE: sbox_inv = 4'h9;  4'hF: sbox_inv = 4'hA;
        endcase
    endfunction

    // First nibble handled in the current beat.
    assign base = 32'(k_q) * SPC;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        work_d     = work_q;
        mode_d     = mode_q;
        out_data_d = out_data_q;
        out_mode_d = out_mode_q;
        if (clr) begin
            state_d = StIdle;
            k_d     = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        work_d  = bus.in_data;
                        mode_d  = bus.in_mode;
                        k_d     = '0;
                        state_d = StRun;
                    end
                end
                StRun: begin
                    for (int unsigned j = 0; j < SPC; j++) begin
                        work_d[4*(base+j) +: 4] = mode_q ? sbox_inv(work_q[4*(base+j) +: 4])
                                                         : sbox_fwd(work_q[4*(base+j) +: 4]);
                    end
                    if (k_q == KW'(BEATS - 1)) begin
                        state_d    = StDone;
                        out_data_d = work_d;
                        out_mode_d = mode_q;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            k_q        <= '0;
            work_q     <= '0;
            mode_q     <= 1'b0;
            out_data_q <= '0;
            out_mode_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            work_q     <= work_d;
            mode_q     <= mode_d;
            out_data_q <= out_data_d;
            out_mode_q <= out_mode_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle) && !clr;
    assign bus.out_valid = (state_q == StDone);
    assign bus.out_data  = out_data_q;
    assign bus.out_mode  = out_mode_q;
    assign busy          = (state_q != StIdle);
endmodule

// File: tb/tb_present_sbox_layer.sv
// Scoreboard bench for present_sbox_layer: SPC=4 main instance plus an SPC=16 instance.
module tb_present_sbox_layer;
    localparam int unsigned NLANES = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic clr16 = 1'b0;
    logic busy, busy16;

    present_sbox_layer_if #(.NLANES(NLANES)) bif ();
    present_sbox_layer_if #(.NLANES(NLANES)) bif16 ();

    present_sbox_layer #(.NLANES(NLANES), .SPC(4)) dut (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy), .bus(bif)
    );
    present_sbox_layer #(.NLANES(NLANES), .SPC(16)) dut16 (
        .clk(clk), .rst(rst), .clr(clr16), .busy(busy16), .bus(bif16)
    );

    always #5 clk = ~clk;

    logic [3:0] fwd_t [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                               4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    logic [3:0] inv_t [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                               4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};

    function automatic logic [63:0] model(input logic m, input logic [63:0] d);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[4*i +: 4] = m ? inv_t[d[4*i +: 4]] : fwd_t[d[4*i +: 4]];
        end
        return r;
    endfunction

    typedef struct {
        logic        mode;
        logic [63:0] data;
        int          acc;
    } exp_t;

    exp_t sb [$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    logic ov_prev  = 1'b0;
    int   last_out = -1;
    bit   b2b      = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: latency on rising out_valid, data/mode on each handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (bif.out_valid && !ov_prev && sb.size() > 0)
                check_eq("latency", 64'(cyc - sb[0].acc), 64'd5);
            if (bif.out_valid && bif.out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_output", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("out_data", bif.out_data, mon_e.data);
                    check_eq("out_mode", 64'(bif.out_mode), 64'(mon_e.mode));
                end
                if (b2b && last_out >= 0) check_eq("b2b_period", 64'(cyc - last_out), 64'd6);
                last_out = cyc;
            end
            ov_prev = bif.out_valid;
        end else begin
            ov_prev = 1'b0;
        end
    end

    task automatic send(input logic m, input logic [63:0] d, input logic [63:0] e);
        int   t;
        exp_t x;
        t = 0;
        bif.in_valid = 1'b1;
        bif.in_mode  = m;
        bif.in_data  = d;
        @(negedge clk);
        while (!bif.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bif.in_ready) begin
            check_eq("accept_timeout", 64'd0, 64'd1);
        end else begin
            x.mode = m;
            x.data = e;
            x.acc  = cyc;
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
        // Scramble inputs so the in-flight word must not depend on them.
        bif.in_valid = 1'b0;
        bif.in_mode  = ~m;
        bif.in_data  = {$urandom, $urandom};
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) check_eq("drain_timeout", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        logic [63:0] held;
        int          t;
        bit          rose;
        int          c0;

        bif.in_valid = 1'b0; bif.in_mode = 1'b0; bif.in_data = '0; bif.out_ready = 1'b1;
        bif16.in_valid = 1'b0; bif16.in_mode = 1'b0; bif16.in_data = '0;
        bif16.out_ready = 1'b1;

        #1;
        check_eq("rst_out_valid", 64'(bif.out_valid), 64'd0);
        check_eq("rst_out_data", bif.out_data, 64'd0);
        check_eq("rst_out_mode", 64'(bif.out_mode), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("in_ready_after_rst", 64'(bif.in_ready), 64'd1);

        send(1'b0, 64'h0123456789ABCDEF, 64'hC56B90AD3EF84712);
        drain();
        send(1'b1, 64'hC56B90AD3EF84712, 64'h0123456789ABCDEF);
        drain();
        send(1'b1, 64'h0123456789ABCDEF, 64'h5EF8C12DB463079A);
        drain();

        // Backpressure
        bif.out_ready = 1'b0;
        d = 64'hDEADBEEFCAFEF00D;
        send(1'b0, d, model(1'b0, d));
        t = 0;
        while (!bif.out_valid && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_eq("bp_valid_seen", 64'(bif.out_valid), 64'd1);
        held = bif.out_data;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_out_valid", 64'(bif.out_valid), 64'd1);
            check_eq("bp_out_data", bif.out_data, held);
            check_eq("bp_in_ready", 64'(bif.in_ready), 64'd0);
        end
        bif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp_release_in_ready", 64'(bif.in_ready), 64'd1);
        check_eq("bp_release_out_valid", 64'(bif.out_valid), 64'd0);
        check_eq("bp_release_busy", 64'(busy), 64'd0);

        // Back-to-back round trips
        b2b = 1'b1;
        last_out = -1;
        for (int i = 0; i < 4; i++) begin
            d = {$urandom, $urandom};
            send(1'b0, d, model(1'b0, d));
            send(1'b1, model(1'b0, d), d);
        end
        drain();
        b2b = 1'b0;

        // clr in the second RUN cycle
        d = 64'h1122334455667788;
        send(1'b0, d, model(1'b0, d));
        @(posedge clk);
        #1;
        clr = 1'b1;
        #1;
        check_eq("clr_busy_before", 64'(busy), 64'd1);
        check_eq("clr_in_ready", 64'(bif.in_ready), 64'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        #1;
        check_eq("clr_idle_in_ready", 64'(bif.in_ready), 64'd1);
        check_eq("clr_idle_busy", 64'(busy), 64'd0);
        sb.delete();
        rose = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bif.out_valid) rose = 1'b1;
        end
        check_eq("clr_no_valid", 64'(rose), 64'd0);
        d = 64'hA5A5F00F0FF05A5A;
        send(1'b1, d, model(1'b1, d));
        drain();

        // Async reset while in DONE
        bif.out_ready = 1'b0;
        d = 64'h0F1E2D3C4B5A6978;
        send(1'b0, d, model(1'b0, d));
        t = 0;
        while (!bif.out_valid && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_eq("rst_done_valid_seen", 64'(bif.out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_out_valid", 64'(bif.out_valid), 64'd0);
        check_eq("arst_out_data", bif.out_data, 64'd0);
        check_eq("arst_busy", 64'(busy), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bif.out_ready = 1'b1;
        d = 64'h0000FFFF1234ABCD;
        send(1'b0, d, model(1'b0, d));
        drain();

        // SPC=16 build: single RUN beat
        bif16.in_valid = 1'b1;
        bif16.in_mode  = 1'b0;
        bif16.in_data  = 64'hFFFFFFFFFFFFFFFF;
        @(negedge clk);
        check_eq("s16_in_ready", 64'(bif16.in_ready), 64'd1);
        c0 = cyc;
        @(posedge clk);
        #1;
        bif16.in_valid = 1'b0;
        bif16.in_data  = '0;
        t = 0;
        @(negedge clk);
        while (!bif16.out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_eq("s16_latency", 64'(cyc - c0), 64'd2);
        check_eq("s16_out_data", bif16.out_data, 64'h2222222222222222);
        check_eq("s16_out_mode", 64'(bif16.out_mode), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
